mf7_frame_accum: RTL and testbench
==================================

// Module: mf7_frame_accum
// PURPOSE
//  Downstream consumer of the 11-bit int -> 7-bit minifloat converter. Accepts a stream of
//  7-bit codes (4-bit exponent, 3-bit mantissa) over valid/ready and decodes each code back to
//  an integer. Sums the decoded values over a frame of FRAME_LEN samples, or fewer on early flush.
//  Per frame it emits the sum, the sample count and the largest code seen.
// PARAMETERS
//  FRAME_LEN  16                        samples per frame (>=2)
//  CNT_W      $clog2(FRAME_LEN+1)       count width (derived, do not override)
//  ACC_W      18+CNT_W                  sum width (derived, do not override)
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      input code valid
//  in_ready   out  1      block can accept a code this cycle
//  in_code    in   7      [6:3]=exponent e, [2:0]=mantissa m
//  in_flush   in   1      close current frame early; sampled only while in_ready=1
//  out_valid  out  1      frame result valid
//  out_ready  in   1      downstream accepts result
//  out_sum    out  ACC_W  sum of decoded values in frame
//  out_count  out  CNT_W  number of samples in frame (1..FRAME_LEN)
//  out_max    out  7      largest in_code in frame (codes are monotonic in unsigned order)
// BEHAVIOUR
//  Decode: e==0 -> value=m; e>0 -> value={1'b1,m} << (e-1); exact, 18-bit unsigned, no rounding.
//  Pipeline: S1 registers the decoded value, count and max update on accept; S2 adds S1 into acc.
//  FSM states:
//   ACCUM: in_ready=1. Accept when in_valid&in_ready. Go to CLOSE when count reaches FRAME_LEN,
//     or when in_flush=1 and (count>0 or a beat is accepted this cycle).
//   CLOSE: in_ready=0, one cycle, drains S1 into acc. Always goes to DONE.
//   DONE: out_valid=1, outputs held stable. On out_ready: clear acc, count and max, go to ACCUM.
//  Latency: last beat accepted in cycle t -> out_valid=1 in cycle t+2. Minimum frame period is
//   FRAME_LEN+2 cycles with out_ready tied high.
//  Flush cases:
//   - in_flush with count==0 and no beat accepted: ignored, no empty frame is emitted.
//   - in_flush together with an accepted beat: that beat is included and the frame closes once.
//   - in_flush while in_ready=0: ignored, not remembered.
//  in_code is ignored while in_ready=0. No backpressure bubbles in ACCUM.
//  Sum never overflows: FRAME_LEN*245760 fits ACC_W. Count wraps to 0 only through DONE.
//  Reset (any state, including mid-frame or while out_valid=1):
//   - state=ACCUM, in_ready=1 in the first cycle after reset.
//   - out_valid=0, out_sum=0, out_count=0, out_max=0.
//   - the partial frame is discarded and S1 is invalidated.
// TESTING
//  1. FRAME_LEN=16, 16 beats of 0x4F (3840), out_ready=1 -> out_sum=61440, out_count=16,
//     out_max=0x4F, out_valid exactly 2 cycles after 16th accept.
//  2. Codes 0x00,0x07,0x08,0x7F then flush on the 4th beat -> sum=0+7+8+245760=245775,
//     count=4, max=0x7F.
//  3. in_flush with count==0 -> no out_valid. Flush asserted in CLOSE/DONE -> ignored,
//     next frame unaffected.
//  4. Hold out_ready=0 for 10 cycles in DONE with in_valid=1 -> in_ready=0, outputs stable,
//     no beat lost. Frame starts fresh after handshake.
//  5. Assert rst after 5 beats, then send 16 beats of 0x08 -> sum=128, count=16
//     (no residue from aborted frame).
//  6. Random codes with random valid/ready gaps, 1000 frames -> match golden decode-and-sum model.

Source files
------------

// File: rtl/mf7_frame_accum.sv
// Frame accumulator for 7-bit minifloat codes: decodes each accepted code to an exact integer,
// sums one frame of FRAME_LEN samples (or fewer on flush) and reports sum, count and largest code.
module mf7_frame_accum #(
   parameter int unsigned FRAME_LEN = 16,
   parameter int unsigned CNT_W     = $clog2(FRAME_LEN + 1),
   parameter int unsigned ACC_W     = 18 + CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       in_code,
   input  logic             in_flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic [6:0]       out_max
);

   typedef enum logic [1:0] {StAccum, StClose, StDone} state_e;

   state_e           state_q;
   logic [ACC_W-1:0] acc_q;
   logic [CNT_W-1:0] count_q;
   logic [6:0]       max_q;
   logic             s1_valid_q;
   logic [17:0]      s1_val_q;
   logic             in_ready_q;
   logic             out_valid_q;

   logic             accept;
   logic [17:0]      dec_val;
   logic [CNT_W-1:0] count_inc;
   logic             close_now;
   logic [ACC_W-1:0] acc_add;

   always_comb begin
      dec_val = '0;
      if (in_code[6:3] == 4'd0) begin
         dec_val = {15'd0, in_code[2:0]};
      end else begin
         dec_val = {14'd0, 1'b1, in_code[2:0]} << (in_code[6:3] - 4'd1);
      end
   end

   always_comb begin
      accept    = in_valid & in_ready_q;
      count_inc = count_q + CNT_W'(accept);
      // Flush only closes a frame that holds at least one sample, counting this cycle's beat.
      close_now = (count_inc == CNT_W'(FRAME_LEN)) || (in_flush && (count_inc != '0));
      acc_add   = s1_valid_q ? ACC_W'(s1_val_q) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StAccum;
         acc_q       <= '0;
         count_q     <= '0;
         max_q       <= '0;
         s1_valid_q  <= 1'b0;
         s1_val_q    <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StAccum: begin
               acc_q      <= acc_q + acc_add;
               s1_valid_q <= accept;
               if (accept) begin
                  s1_val_q <= dec_val;
                  count_q  <= count_inc;
                  if (in_code > max_q) max_q <= in_code;
               end
               if (close_now) begin
                  state_q    <= StClose;
                  in_ready_q <= 1'b0;
               end
            end
            StClose: begin
               acc_q       <= acc_q + acc_add;
               s1_valid_q  <= 1'b0;
               out_valid_q <= 1'b1;
               state_q     <= StDone;
            end
            StDone: begin
               if (out_ready) begin
                  acc_q       <= '0;
                  count_q     <= '0;
                  max_q       <= '0;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= StAccum;
               end
            end
            default: begin
               state_q    <= StAccum;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = acc_q;
   assign out_count = count_q;
   assign out_max   = max_q;

endmodule

// File: tb/tb_mf7_frame_accum.sv
// Scoreboard bench for mf7_frame_accum: the driver pushes expected frames, a negedge monitor
// compares every presented result against the queue head and pops on handshake.
module tb_mf7_frame_accum;

   localparam int FRAME_LEN = 16;
   localparam int CNT_W     = 5;
   localparam int ACC_W     = 23;

   typedef struct {
      logic [ACC_W-1:0] sum;
      logic [CNT_W-1:0] cnt;
      logic [6:0]       mx;
   } frame_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [6:0]       in_code = '0;
   logic             in_flush = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0] out_count;
   logic [6:0]       out_max;

   frame_t exp_q[$];
   int     n_cmp = 0;
   int     n_err = 0;
   int     cyc = 0;
   int     last_acc_cyc = 0;
   int     rdy_mode = 1;
   bit     check_lat = 1'b0;
   bit     auto_push = 1'b0;
   logic   prev_ov = 1'b0;
   int     n_frames = 0;

   int          m_cnt = 0;
   int unsigned m_sum = 0;
   logic [6:0]  m_max = '0;

   mf7_frame_accum #(.FRAME_LEN(FRAME_LEN)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_code  (in_code),
      .in_flush (in_flush),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum  (out_sum),
      .out_count(out_count),
      .out_max  (out_max)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   function automatic int unsigned gold(input logic [6:0] c);
      int unsigned e = c[6:3];
      int unsigned m = c[2:0];
      if (e == 0) return m;
      return (8 + m) * (32'd1 << (e - 1));
   endfunction

   task automatic push_frame(input int unsigned s, input int c, input logic [6:0] mx);
      frame_t f;
      f.sum = ACC_W'(s);
      f.cnt = CNT_W'(c);
      f.mx  = mx;
      exp_q.push_back(f);
   endtask

   task automatic model_close();
      if (auto_push) push_frame(m_sum, m_cnt, m_max);
      n_frames++;
      m_cnt = 0;
      m_sum = 0;
      m_max = '0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_flush = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called at posedge+1; holds the beat until accepted, returns at posedge+1 after the accept.
   task automatic send(input logic [6:0] code, input bit fl);
      bit done = 1'b0;
      in_valid = 1'b1;
      in_code  = code;
      in_flush = fl;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            done = 1'b1;
            last_acc_cyc = cyc;
            m_cnt++;
            m_sum += gold(code);
            if (code > m_max) m_max = code;
            if (m_cnt == FRAME_LEN || fl) model_close();
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout code=%h in_ready=%b", code, in_ready);
      end
      in_valid = 1'b0;
      in_flush = 1'b0;
   endtask

   task automatic flush_only();
      in_valid = 1'b0;
      in_flush = 1'b1;
      @(negedge clk);
      if (in_ready === 1'b1 && m_cnt > 0) model_close();
      @(posedge clk);
      #1;
      in_flush = 1'b0;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      in_flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      m_cnt = 0;
      m_sum = 0;
      m_max = '0;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 || out_count !== '0 ||
          out_max !== '0) begin
         n_err++;
         $display("FAIL reset_state got rdy=%b ov=%b sum=%0d cnt=%0d max=%h want 1 0 0 0 00",
                  in_ready, out_valid, out_sum, out_count, out_max);
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: every cycle with out_valid is checked against the head, so holding is checked too.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid === 1'b1) begin
            if (prev_ov !== 1'b1 && check_lat) begin
               n_cmp++;
               if (cyc - last_acc_cyc != 2) begin
                  n_err++;
                  $display("FAIL latency got %0d cycles want 2", cyc - last_acc_cyc);
               end
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_frame sum=%0d cnt=%0d max=%h want none",
                        out_sum, out_count, out_max);
            end else begin
               if (out_sum !== exp_q[0].sum || out_count !== exp_q[0].cnt ||
                   out_max !== exp_q[0].mx) begin
                  n_err++;
                  $display("FAIL frame got sum=%0d cnt=%0d max=%h want sum=%0d cnt=%0d max=%h",
                           out_sum, out_count, out_max, exp_q[0].sum, exp_q[0].cnt, exp_q[0].mx);
               end
               if (out_ready === 1'b1) void'(exp_q.pop_front());
            end
         end
      end
      prev_ov <= out_valid;
   end

   initial begin
      bit seen;
      do_reset();

      // Full frame of 0x4F (3840 each), latency checked.
      rdy_mode  = 1;
      check_lat = 1'b1;
      for (int i = 0; i < 16; i++) send(7'h4F, 1'b0);
      push_frame(61440, 16, 7'h4F);
      idle(4);
      check_lat = 1'b0;

      // Early flush on the 4th beat.
      send(7'h00, 1'b0);
      send(7'h07, 1'b0);
      send(7'h08, 1'b0);
      send(7'h7F, 1'b1);
      push_frame(245775, 4, 7'h7F);
      idle(4);

      // Flush on an empty frame must not produce a result.
      flush_only();
      idle(3);

      // Flush during CLOSE/DONE ignored; DONE held with in_valid=1 and out_ready=0.
      rdy_mode = 0;
      for (int i = 0; i < 16; i++) send(7'h01, 1'b0);
      push_frame(16, 16, 7'h01);
      flush_only();
      flush_only();
      in_valid = 1'b1;
      in_code  = 7'h09;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_cmp++;
         if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ready_in_done got %b want 0", in_ready);
         end
         @(posedge clk);
         #1;
      end
      rdy_mode = 1;
      for (int i = 0; i < 16; i++) send(7'h09, 1'b0);
      push_frame(144, 16, 7'h09);
      idle(4);

      // Reset mid-frame, then a clean frame of 0x08.
      for (int i = 0; i < 5; i++) send(7'h20, 1'b0);
      do_reset();
      for (int i = 0; i < 16; i++) send(7'h08, 1'b0);
      push_frame(128, 16, 7'h08);
      idle(4);

      // Reset while a result is being held.
      rdy_mode = 0;
      for (int i = 0; i < 16; i++) send(7'h02, 1'b0);
      push_frame(32, 16, 7'h02);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("FAIL held_frame_timeout out_valid=%b want 1", out_valid);
      end
      @(posedge clk);
      #1;
      do_reset();
      rdy_mode = 1;

      // Random codes, gaps, flushes and backpressure against the golden model.
      auto_push = 1'b1;
      rdy_mode  = 2;
      n_frames  = 0;
      while (n_frames < 1000) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         send(7'($urandom_range(0, 127)), $urandom_range(0, 29) == 0);
      end
      if (m_cnt > 0) flush_only();
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      rdy_mode = 1;
      idle(4);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain got %0d frames pending want 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
